// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub block.
//   NIBBLE   : width of the arithmetic slice driven each cycle
//   ADD/SUB  : values of the mode bit m
//   state_e  : controller state encoding (IDLE, RUN, DONE)
package nibble_serial_addsub_pkg;

  localparam int   NIBBLE = 4;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// 4-bit two's-complement add/sub slice and its 1-bit full adder.
// addsub_slice_4bit ports:
//   a4, b4 : nibble operands
//   m      : 0 = add, 1 = subtract (b4 is inverted; the +1 arrives via cin)
//   cin    : carry in, supplied by the caller's carry register
//   s4     : nibble sum
//   cout   : carry out of the top bit
// Purely combinational; no carry-in override or sign correction inside.

module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_slice_4bit
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIBBLE-1:0] a4,
  input  logic [NIBBLE-1:0] b4,
  input  logic              m,
  input  logic              cin,
  output logic [NIBBLE-1:0] s4,
  output logic              cout
);
  logic [NIBBLE-1:0] bx;
  logic [NIBBLE:0]   c;

  assign bx   = b4 ^ {NIBBLE{m}};
  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
    full_adder_1bit u_fa (
      .a    (a4[i]),
      .b    (bx[i]),
      .cin  (c[i]),
      .s    (s4[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[NIBBLE];
endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit two's-complement adder/subtractor. Operands are
// captured on an accepted start, then one nibble per clock (LSB first) is
// pushed through a single 4-bit add/sub slice, with the carry held in a
// register between nibbles.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : request, sampled only in IDLE
//   m        : 0 = add, 1 = subtract (a - b)
//   a, b     : operands, captured on accepted start
//   busy     : high in RUN and DONE
//   done     : one-cycle pulse; result/cout/ovf valid
//   result   : two's-complement sum/difference (mod 2^WIDTH)
//   cout     : final carry (subtract: 1 = no borrow)
//   ovf      : signed overflow of the full-width operation
// WIDTH must be a multiple of 4 and at least 4.

module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int NNIB  = WIDTH / NIBBLE;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NNIB - 1);

  state_e            state;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              m_q;

  logic [NIBBLE-1:0] a_nib, b_nib, s_nib;
  logic              c_nib;
  logic              ovf_nxt;

  assign a_nib = a_q[idx*NIBBLE +: NIBBLE];
  assign b_nib = b_q[idx*NIBBLE +: NIBBLE];

  addsub_slice_4bit u_slice (
    .a4   (a_nib),
    .b4   (b_nib),
    .m    (m_q),
    .cin  (carry),
    .s4   (s_nib),
    .cout (c_nib)
  );

  // The top nibble's sum bit is the result MSB being written this cycle,
  // so overflow is taken from the slice output rather than from result.
  assign ovf_nxt = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ m_q)) &&
                   (s_nib[NIBBLE-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            carry <= (m == SUB);  // subtract injects the +1 of ~b + 1
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result[idx*NIBBLE +: NIBBLE] <= s_nib;
          carry <= c_nib;
          if (idx == LAST) begin
            cout  <= c_nib;
            ovf   <= ovf_nxt;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;
  import nibble_serial_addsub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst8, start8, m8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, res8;
  // 16-bit instance
  logic        rst16, start16, m16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, res16;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .m(m8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  nibble_serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .m(m16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .cout(cout16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation: done expected two edges after the accepting edge.
  task automatic run8(input string tag, input logic mm, input logic [7:0] aa,
                      input logic [7:0] bb, input logic [7:0] er,
                      input logic ec, input logic eo);
    int cnt;
    @(negedge clk);
    start8 = 1'b1; m8 = mm; a8 = aa; b8 = bb;
    @(posedge clk); #1;
    start8 = 1'b0; m8 = ~mm; a8 = ~aa; b8 = ~bb;  // operands must be latched
    chk({tag, ".busy"}, 32'(busy8), 32'd1);
    cnt = 0;
    while (!done8 && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, ".lat"},  cnt,         32'd2);
    chk({tag, ".res"},  32'(res8),   32'(er));
    chk({tag, ".cout"}, 32'(cout8),  32'(ec));
    chk({tag, ".ovf"},  32'(ovf8),   32'(eo));
    @(posedge clk); #1;
    chk({tag, ".done_low"}, 32'(done8), 32'd0);
    chk({tag, ".busy_low"}, 32'(busy8), 32'd0);
    chk({tag, ".hold"},     32'(res8),  32'(er));
  endtask

  int ndone, dc;
  logic [15:0] res_at_done;
  logic        cout_at_done, ovf_at_done;

  initial begin
    rst8 = 1'b1; rst16 = 1'b1;
    start8 = 0; m8 = ADD; a8 = '0; b8 = '0;
    start16 = 0; m16 = ADD; a16 = '0; b16 = '0;
    #1;
    chk("rst.busy8", 32'(busy8), 0);
    chk("rst.done8", 32'(done8), 0);
    chk("rst.res8",  32'(res8),  0);
    chk("rst.cout8", 32'(cout8), 0);
    chk("rst.ovf8",  32'(ovf8),  0);
    chk("rst.res16", 32'(res16), 0);
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0; rst16 = 1'b0;

    // 8-bit directed vectors
    run8("add5a3c", ADD, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run8("sub3c5a", SUB, 8'h3C, 8'h5A, 8'hE2, 1'b0, 1'b0);
    run8("sub5a3c", SUB, 8'h5A, 8'h3C, 8'h1E, 1'b1, 1'b0);
    run8("sub8001", SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run8("addff01", ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

    // 16-bit: starts while busy (RUN at +1/+3, DONE at +5) are ignored
    @(negedge clk);
    start16 = 1'b1; m16 = ADD; a16 = 16'h1234; b16 = 16'h0FFF;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
    ndone = 0; dc = 0; res_at_done = '0; cout_at_done = 1'b1; ovf_at_done = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      start16 = (c == 1 || c == 3 || c == 5);
      @(posedge clk); #1;
      start16 = 1'b0;
      if (done16) begin
        ndone++;
        dc = c;
        res_at_done = res16; cout_at_done = cout16; ovf_at_done = ovf16;
      end
    end
    chk("w16.ndone", ndone, 1);
    chk("w16.lat",   dc,    4);
    chk("w16.res",   32'(res_at_done),  32'h2233);
    chk("w16.cout",  32'(cout_at_done), 0);
    chk("w16.ovf",   32'(ovf_at_done),  0);
    chk("w16.idle",  32'(busy16), 0);
    chk("w16.hold",  32'(res16),  32'h2233);

    // 16-bit: reset during RUN
    @(negedge clk);
    start16 = 1'b1; m16 = SUB; a16 = 16'h1111; b16 = 16'h2222;
    @(posedge clk); #1 start16 = 1'b0;
    @(posedge clk); #1;
    chk("rr.busy_run", 32'(busy16), 1);
    rst16 = 1'b1;
    #1;
    chk("rr.busy", 32'(busy16), 0);
    chk("rr.done", 32'(done16), 0);
    chk("rr.res",  32'(res16),  0);
    chk("rr.cout", 32'(cout16), 0);
    chk("rr.ovf",  32'(ovf16),  0);
    @(posedge clk); #1 rst16 = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done16) ndone++;
    end
    chk("rr.nodone", ndone, 0);

    // first start after reset completes normally
    @(negedge clk);
    start16 = 1'b1; m16 = ADD; a16 = 16'h7FFF; b16 = 16'h0001;
    @(posedge clk); #1 start16 = 1'b0;
    dc = 0;
    while (!done16 && dc < 12) begin
      @(posedge clk); #1;
      dc++;
    end
    chk("post.lat",  dc, 4);
    chk("post.res",  32'(res16),  32'h8000);
    chk("post.cout", 32'(cout16), 0);
    chk("post.ovf",  32'(ovf16),  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
